// File: rtl/ls_sequencer.sv
// Load/store sequencer: one core request -> one or two word-aligned memory beats.
// Define LS_MISALIGN_EN to split misaligned accesses; otherwise they retire with err.
module ls_sequencer #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [4:0]    lsunit,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata_out,
    output logic          done,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_strobe,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);
    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // a memory beat completes on a rising edge where mem_req && mem_ack.
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t        state, state_d;
    logic [4:0]    unit_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] lo_q, lo_d;
`ifdef LS_MISALIGN_EN
    logic [DW-1:0] hi_q, hi_d;
`endif

    logic          done_d, err_d, req_d, we_d;
    logic [AW-1:0] maddr_d;
    logic [DW-1:0] mwdata_d, rdata_d;
    logic [3:0]    strobe_d;

    // While idle the live request is decoded so beat 0 can be registered on acceptance
    logic [4:0]    unit_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] wdata_s;
    assign unit_s  = (state == IDLE) ? lsunit  : unit_q;
    assign addr_s  = (state == IDLE) ? address : addr_q;
    assign wdata_s = (state == IDLE) ? wdata   : wdata_q;

    logic [1:0]      off;
    logic            illegal, misal;
    logic [2:0]      nbytes;
    logic [3:0]      nmask;
    logic [7:0]      m8;
    logic [DW-1:0]   wsized;
    logic [2*DW-1:0] d64;
    logic [AW-1:0]   base;
    logic            accept;

    assign off     = addr_s[1:0];
    assign illegal = (unit_s[1:0] == 2'b11) || (unit_s[2] && unit_s[1]);
    assign misal   = ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
    assign m8      = {4'b0000, nmask} << off;
    assign d64     = {{DW{1'b0}}, wsized} << {off, 3'b000};
    assign base    = {addr_s[AW-1:2], 2'b00};
    assign accept  = (state == IDLE) && req_valid && lsunit[4];
    assign req_ready = (state == IDLE);

    always_comb begin
        nbytes = 3'd4;
        nmask  = 4'b1111;
        wsized = wdata_s;
        case (unit_s[1:0])
            2'b00: begin nbytes = 3'd1; nmask = 4'b0001; wsized = {{(DW-8){1'b0}}, wdata_s[7:0]}; end
            2'b01: begin nbytes = 3'd2; nmask = 4'b0011; wsized = {{(DW-16){1'b0}}, wdata_s[15:0]}; end
            default: ;
        endcase
    end

`ifndef LS_MISALIGN_EN
    logic unused_upper;
    assign unused_upper = ^{m8[7:4], d64[2*DW-1:DW]};
`endif

    // Load assembly: the two beats form a 64-bit window shifted down by the byte offset
    logic [2*DW-1:0] word;
    logic [DW-1:0]   shifted, result;
    always_comb begin
`ifdef LS_MISALIGN_EN
        word = {hi_d, lo_d};
`else
        word = {{DW{1'b0}}, lo_d};
`endif
        shifted = DW'(word >> {off, 3'b000});
        case (unit_s[2:0])
            3'b000:  result = {{(DW-8){shifted[7]}}, shifted[7:0]};
            3'b001:  result = {{(DW-16){shifted[15]}}, shifted[15:0]};
            3'b100:  result = {{(DW-8){1'b0}}, shifted[7:0]};
            3'b101:  result = {{(DW-16){1'b0}}, shifted[15:0]};
            default: result = shifted;
        endcase
        if (unit_s[3]) result = '0;
    end

    always_comb begin
        state_d  = state;
        done_d   = 1'b0;
        err_d    = 1'b0;
        req_d    = 1'b0;
        we_d     = 1'b0;
        maddr_d  = '0;
        mwdata_d = '0;
        strobe_d = 4'b0000;
        rdata_d  = rdata_out;
        lo_d     = lo_q;
`ifdef LS_MISALIGN_EN
        hi_d     = hi_q;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef LS_MISALIGN_EN
                    if (illegal) begin
`else
                    if (illegal || misal) begin
`endif
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d  = BEAT0;
                        req_d    = 1'b1;
                        we_d     = unit_s[3];
                        maddr_d  = base;
                        mwdata_d = d64[DW-1:0];
                        strobe_d = unit_s[3] ? m8[3:0] : 4'b0000;
                    end
                end
            end
            BEAT0: begin
                if (mem_ack) begin
                    lo_d = mem_rdata;
`ifdef LS_MISALIGN_EN
                    if (misal) begin
                        state_d  = BEAT1;
                        req_d    = 1'b1;
                        we_d     = unit_s[3];
                        maddr_d  = base + AW'(4);
                        mwdata_d = d64[2*DW-1:DW];
                        strobe_d = unit_s[3] ? m8[7:4] : 4'b0000;
                    end else
`endif
                    begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        rdata_d = result;
                    end
                end else begin
                    req_d    = 1'b1;
                    we_d     = unit_s[3];
                    maddr_d  = base;
                    mwdata_d = d64[DW-1:0];
                    strobe_d = unit_s[3] ? m8[3:0] : 4'b0000;
                end
            end
`ifdef LS_MISALIGN_EN
            BEAT1: begin
                if (mem_ack) begin
                    hi_d    = mem_rdata;
                    state_d = RESP;
                    done_d  = 1'b1;
                    rdata_d = result;
                end else begin
                    req_d    = 1'b1;
                    we_d     = unit_s[3];
                    maddr_d  = base + AW'(4);
                    mwdata_d = d64[2*DW-1:DW];
                    strobe_d = unit_s[3] ? m8[7:4] : 4'b0000;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_strobe <= 4'b0000;
            rdata_out  <= '0;
            unit_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
`ifdef LS_MISALIGN_EN
            hi_q       <= '0;
`endif
        end else begin
            state      <= state_d;
            done       <= done_d;
            err        <= err_d;
            mem_req    <= req_d;
            mem_we     <= we_d;
            mem_addr   <= maddr_d;
            mem_wdata  <= mwdata_d;
            mem_strobe <= strobe_d;
            rdata_out  <= rdata_d;
            lo_q       <= lo_d;
`ifdef LS_MISALIGN_EN
            hi_q       <= hi_d;
`endif
            if (accept) begin
                unit_q  <= lsunit;
                addr_q  <= address;
                wdata_q <= wdata;
            end
        end
    end
endmodule

// File: tb/tb_ls_sequencer.sv
// Directed bench for ls_sequencer; misalignment vectors follow LS_MISALIGN_EN.
module tb_ls_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  lsunit;
    logic [31:0] address, wdata, rdata_out;
    logic        done, err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_strobe;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    localparam logic [4:0] LB = 5'b10000, LH = 5'b10001, LW = 5'b10010;
    localparam logic [4:0] LBU = 5'b10100, LHU = 5'b10101;
    localparam logic [4:0] SB = 5'b11000, SH = 5'b11001, SW = 5'b11010;

    ls_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .lsunit(lsunit), .address(address), .wdata(wdata), .rdata_out(rdata_out),
        .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strobe(mem_strobe),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    // driver: one access, memory answers after waitc idle cycles per beat
    task automatic xact(input string tag, input logic [4:0] unit, input logic [31:0] addr,
                        input logic [31:0] wd, input int beats,
                        input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] w0,
                        input logic [31:0] r0,
                        input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] w1,
                        input logic [31:0] r1,
                        input logic [31:0] exp_rd, input logic exp_err, input int waitc);
        logic [31:0] ea, ew, er;
        logic [3:0]  es;
        logic [31:0] got_rd;
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        lsunit    = unit;
        address   = addr;
        wdata     = wd;
        exp_q.push_back(exp_rd);
        @(negedge clk);
        req_valid = 1'b0;
        for (int b = 0; b < beats; b++) begin
            ea = (b == 0) ? a0 : a1;
            es = (b == 0) ? s0 : s1;
            ew = (b == 0) ? w0 : w1;
            er = (b == 0) ? r0 : r1;
            check({tag, ".req"},    32'(mem_req),    32'd1);
            check({tag, ".busy"},   32'(req_ready),  32'd0);
            check({tag, ".we"},     32'(mem_we),     32'(unit[3]));
            check({tag, ".addr"},   mem_addr,        ea);
            check({tag, ".strobe"}, 32'(mem_strobe), 32'(es));
            check({tag, ".wdata"},  mem_wdata,       ew);
            for (int i = 0; i < waitc; i++) begin
                @(negedge clk);
                check({tag, ".hold_req"},  32'(mem_req),   32'd1);
                check({tag, ".hold_addr"}, mem_addr,       ea);
                check({tag, ".hold_data"}, {mem_wdata[31:4], mem_strobe}, {ew[31:4], es});
            end
            mem_ack   = 1'b1;
            mem_rdata = er;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
        end
        check({tag, ".done"},    32'(done),    32'd1);
        check({tag, ".err"},     32'(err),     32'(exp_err));
        check({tag, ".req_off"}, 32'(mem_req), 32'd0);
        got_rd = rdata_out;
        if (exp_q.size() > 0) check({tag, ".rdata"}, got_rd, exp_q.pop_front());
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; lsunit = 5'b0; address = 32'h0; wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.outs", {27'b0, done, err, mem_req, mem_we, |mem_strobe}, 32'd0);
        check("rst.addr", mem_addr, 32'h0);
        check("rst.rdata", rdata_out, 32'h0);

        xact("lw",  LW,  32'h100, 32'h0, 1, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF,
             32'h0, 4'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        xact("lb",  LB,  32'h103, 32'h0, 1, 32'h100, 4'b0000, 32'h0, 32'h80123456,
             32'h0, 4'b0, 32'h0, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        xact("lbu", LBU, 32'h103, 32'h0, 1, 32'h100, 4'b0000, 32'h0, 32'h80123456,
             32'h0, 4'b0, 32'h0, 32'h0, 32'h00000080, 1'b0, 0);
        xact("sh",  SH,  32'h202, 32'h0000ABCD, 1, 32'h200, 4'b1100, 32'hABCD0000, 32'h0,
             32'h0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        xact("lh",  LH,  32'h102, 32'h0, 1, 32'h100, 4'b0000, 32'h0, 32'h80011234,
             32'h0, 4'b0, 32'h0, 32'h0, 32'hFFFF8001, 1'b0, 0);
        xact("lhu", LHU, 32'h102, 32'h0, 1, 32'h100, 4'b0000, 32'h0, 32'h80011234,
             32'h0, 4'b0, 32'h0, 32'h0, 32'h00008001, 1'b0, 0);
        xact("sb",  SB,  32'h001, 32'hFFFFFF5A, 1, 32'h000, 4'b0010, 32'h00005A00, 32'h0,
             32'h0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        xact("sw_wait", SW, 32'h400, 32'h12345678, 1, 32'h400, 4'b1111, 32'h12345678, 32'h0,
             32'h0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5);
        xact("illegal", 5'b10011, 32'h100, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0,
             32'h0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
`ifdef LS_MISALIGN_EN
        xact("lw_split", LW, 32'h301, 32'h0, 2, 32'h300, 4'b0000, 32'h0, 32'h44332211,
             32'h304, 4'b0000, 32'h0, 32'h88776655, 32'h55443322, 1'b0, 0);
        xact("sw_wrap", SW, 32'hFFFFFFFE, 32'h11223344, 2, 32'hFFFFFFFC, 4'b1100, 32'h33440000, 32'h0,
             32'h00000000, 4'b0011, 32'h00001122, 32'h0, 32'h0, 1'b0, 0);
`else
        xact("lw_mis", LW, 32'h301, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0,
             32'h0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
        xact("sh_mis", SH, 32'h003, 32'h0000ABCD, 0, 32'h0, 4'b0, 32'h0, 32'h0,
             32'h0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
`endif
        // a non-access lsunit is ignored
        req_valid = 1'b1; lsunit = 5'b01010; address = 32'h500;
        @(negedge clk);
        req_valid = 1'b0;
        check("ignore.ready", 32'(req_ready), 32'd1);
        check("ignore.quiet", {30'b0, mem_req, done}, 32'd0);

        // leave a nonzero rdata_out, then reset in the middle of BEAT0
        xact("lw2", LW, 32'h104, 32'h0, 1, 32'h104, 4'b0000, 32'h0, 32'hCAFEF00D,
             32'h0, 4'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 0);
        req_valid = 1'b1; lsunit = SW; address = 32'h600; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst.req_before", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.ready", 32'(req_ready), 32'd1);
        check("midrst.outs", {27'b0, done, err, mem_req, mem_we, |mem_strobe}, 32'd0);
        check("midrst.addr", mem_addr, 32'h0);
        check("midrst.wdata", mem_wdata, 32'h0);
        check("midrst.rdata", rdata_out, 32'h0);
        // late ack arriving in IDLE
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_ack = 1'b0;
        check("lateack.quiet", {30'b0, mem_req, done}, 32'd0);
        check("lateack.ready", 32'(req_ready), 32'd1);

        xact("lw3", LW, 32'h108, 32'h0, 1, 32'h108, 4'b0000, 32'h0, 32'h0BADBEEF,
             32'h0, 4'b0, 32'h0, 32'h0, 32'h0BADBEEF, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
